// File: rtl/operand_capture_pkg.sv
// Shared widths, defaults and types for the adder front-end stages.
`timescale 1ns/1ps
package operand_capture_pkg;

   localparam int unsigned DEBOUNCE_DEFAULT = 4;
   localparam int unsigned OPERAND_W        = 2;
   localparam int unsigned CNT_W_DEFAULT    = 8;

   typedef enum logic {
      DB_STABLE   = 1'b0,
      DB_COUNTING = 1'b1
   } db_state_e;

   typedef struct packed {
      logic [OPERAND_W-1:0] a;
      logic [OPERAND_W-1:0] b;
      logic                 ci;
   } operands_t;

   // Counter width able to hold values up to cycles-1 with headroom.
   function automatic int unsigned db_cnt_width(input int unsigned cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counting debouncer for one push-button.
`timescale 1ns/1ps
module button_debounce
   import operand_capture_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic deb
);

   localparam int unsigned CW = db_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   db_state_e     state;
   db_state_e     state_n;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic          deb_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= DB_STABLE;
         cnt   <= '0;
         deb   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         deb   <= deb_n;
      end
   end

   // A bounce back to the debounced level discards the run entirely.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      deb_n   = deb;
      case (state)
         DB_STABLE: begin
            if (sync2 != deb) begin
               state_n = DB_COUNTING;
               cnt_n   = CW'(1);
            end else begin
               cnt_n   = '0;
            end
         end
         DB_COUNTING: begin
            if (sync2 == deb) begin
               state_n = DB_STABLE;
               cnt_n   = '0;
            end else if (cnt == LAST) begin
               state_n = DB_STABLE;
               cnt_n   = '0;
               deb_n   = ~deb;
            end else begin
               cnt_n   = cnt + CW'(1);
            end
         end
         default: begin
            state_n = DB_STABLE;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: rtl/operand_capture.sv
// Synchronises switches, debounces load/clear buttons and holds operands for the adder.
`timescale 1ns/1ps
module operand_capture
   import operand_capture_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [OPERAND_W-1:0] sw_a,
   input  logic [OPERAND_W-1:0] sw_b,
   input  logic                 sw_ci,
   input  logic                 btn_load,
   input  logic                 btn_clear,
   output logic [OPERAND_W-1:0] A,
   output logic [OPERAND_W-1:0] B,
   output logic                 CI,
   output logic                 valid,
   output logic                 load_pulse,
   output logic [CNT_W-1:0]     load_count
);

   operands_t sw_s1;
   operands_t sw_s2;
   logic      deb_load;
   logic      deb_clear;
   logic      deb_load_d;
   logic      deb_clear_d;
   logic      rise_load;
   logic      rise_clear;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
      end else begin
         sw_s1 <= '{a: sw_a, b: sw_b, ci: sw_ci};
         sw_s2 <= sw_s1;
      end
   end

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
      .clk (clk),
      .rst (rst),
      .raw (btn_load),
      .deb (deb_load)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
      .clk (clk),
      .rst (rst),
      .raw (btn_clear),
      .deb (deb_clear)
   );

   // Registered rising edges of the debounced levels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb_load_d  <= 1'b0;
         deb_clear_d <= 1'b0;
         rise_load   <= 1'b0;
         rise_clear  <= 1'b0;
      end else begin
         deb_load_d  <= deb_load;
         deb_clear_d <= deb_clear;
         rise_load   <= deb_load & ~deb_load_d;
         rise_clear  <= deb_clear & ~deb_clear_d;
      end
   end

   // Clear takes priority over a coincident load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         A          <= '0;
         B          <= '0;
         CI         <= 1'b0;
         valid      <= 1'b0;
         load_pulse <= 1'b0;
         load_count <= '0;
      end else begin
         load_pulse <= 1'b0;
         if (rise_clear) begin
            A     <= '0;
            B     <= '0;
            CI    <= 1'b0;
            valid <= 1'b0;
         end else if (rise_load) begin
            A          <= sw_s2.a;
            B          <= sw_s2.b;
            CI         <= sw_s2.ci;
            valid      <= 1'b1;
            load_pulse <= 1'b1;
            load_count <= load_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_operand_capture.sv
// Randomised scoreboard bench for operand_capture with an action-level reference model.
`timescale 1ns/1ps
module tb_operand_capture;

   localparam int unsigned DEB = 4;
   localparam int unsigned CW  = 2;
   localparam int          LAT = DEB + 3;
   localparam int          SETTLE = DEB + 6;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    sw_a, sw_b;
   logic          sw_ci, btn_load, btn_clear;
   logic [1:0]    A, B;
   logic          CI, valid, load_pulse;
   logic [CW-1:0] load_count;

   operand_capture #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .sw_a       (sw_a),
      .sw_b       (sw_b),
      .sw_ci      (sw_ci),
      .btn_load   (btn_load),
      .btn_clear  (btn_clear),
      .A          (A),
      .B          (B),
      .CI         (CI),
      .valid      (valid),
      .load_pulse (load_pulse),
      .load_count (load_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int cyc;
      int a;
      int b;
      int ci;
      int cnt;
   } exp_t;

   exp_t sbq[$];
   int vectors = 0;
   int miscompares = 0;

   // Reference model: held operands and load counter as plain integers.
   int m_a = 0, m_b = 0, m_ci = 0, m_valid = 0, m_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && load_pulse) begin
         if (sbq.size() == 0) begin
            chk("unexpected_pulse", int'(load_pulse), 0);
         end else begin
            e = sbq.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_A", int'(A), e.a);
            chk("pulse_B", int'(B), e.b);
            chk("pulse_CI", int'(CI), e.ci);
            chk("pulse_valid", int'(valid), 1);
            chk("pulse_count", int'(load_count), e.cnt);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_A"}, int'(A), m_a);
      chk({tag, "_B"}, int'(B), m_b);
      chk({tag, "_CI"}, int'(CI), m_ci);
      chk({tag, "_valid"}, int'(valid), m_valid);
      chk({tag, "_count"}, int'(load_count), m_cnt);
   endtask

   task automatic set_sw(input int a, input int b, input int ci);
      sw_a  = 2'(a);
      sw_b  = 2'(b);
      sw_ci = 1'(ci);
      tick(3);
   endtask

   // Model a load decided when the press becomes stable: LAT edges after edge 0.
   task automatic expect_load(input int c0);
      exp_t e;
      m_a = int'(sw_a); m_b = int'(sw_b); m_ci = int'(sw_ci);
      m_valid = 1;
      m_cnt = (m_cnt + 1) % (1 << CW);
      e.cyc = c0 + 1 + LAT; e.a = m_a; e.b = m_b; e.ci = m_ci; e.cnt = m_cnt;
      sbq.push_back(e);
   endtask

   task automatic press_load(input bit bouncy, input int hold, input bit chg);
      if (bouncy) begin
         for (int k = 0; k < 4; k++) begin
            btn_load = (k % 2 == 0);
            tick(2);
         end
      end
      btn_load = 1'b1;
      expect_load(cyc);
      if (chg) begin
         tick(LAT + 3);
         sw_a = ~sw_a;
         sw_b = ~sw_b;
         tick(hold - LAT - 3);
      end else begin
         tick(hold);
      end
      btn_load = 1'b0;
      tick(SETTLE);
      check_state(bouncy ? "bouncy_load" : "load");
   endtask

   task automatic press_clear(input int hold, input bit both);
      btn_clear = 1'b1;
      if (both) btn_load = 1'b1;
      m_a = 0; m_b = 0; m_ci = 0; m_valid = 0;
      tick(hold);
      btn_clear = 1'b0;
      btn_load  = 1'b0;
      tick(SETTLE);
      check_state(both ? "both" : "clear");
   endtask

   initial begin
      rst = 1'b1;
      sw_a = '0; sw_b = '0; sw_ci = 1'b0;
      btn_load = 1'b0; btn_clear = 1'b0;
      tick(3);
      check_state("in_reset");
      rst = 1'b0;
      tick(12);
      check_state("idle");

      // Clean load held long, then bouncy press with switch change while held.
      set_sw(2, 1, 1);
      press_load(1'b0, 50, 1'b0);
      press_load(1'b1, 20, 1'b1);

      // Clear, reload, simultaneous press.
      press_clear(12, 1'b0);
      set_sw(1, 1, 0);
      press_load(1'b0, 12, 1'b0);
      set_sw(3, 3, 1);
      press_clear(12, 1'b1);

      // Switch changes alone leave held operands untouched.
      set_sw(0, 2, 1);
      tick(5);
      check_state("sw_only");

      // Counter wraps.
      for (int i = 0; i < 4; i++) begin
         set_sw(i, 3 - i, i % 2);
         press_load(1'b0, 10, 1'b0);
      end

      // Reset mid-debounce with the button still held afterwards.
      begin
         int c0;
         btn_load = 1'b1;
         tick(3);
         rst = 1'b1;
         m_a = 0; m_b = 0; m_ci = 0; m_valid = 0; m_cnt = 0;
         tick(1);
         check_state("mid_reset");
         tick(1);
         rst = 1'b0;
         c0 = cyc;
         tick(LAT);
         check_state("pre_fresh_load");
         expect_load(c0);
         tick(6);
         btn_load = 1'b0;
         tick(SETTLE);
         check_state("fresh_load");
      end

      // Randomised action mix.
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 4))
            0: begin
               set_sw($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
               check_state("rand_sw");
            end
            1: begin
               set_sw($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
               press_load(1'b0, $urandom_range(10, 20), 1'b0);
            end
            2: begin
               set_sw($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
               press_load(1'b1, $urandom_range(12, 20), 1'($urandom_range(0, 1)));
            end
            3: press_clear($urandom_range(10, 16), 1'b0);
            default: press_clear($urandom_range(10, 16), 1'b1);
         endcase
      end

      tick(20);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
